sample_uart_tx: RTL and testbench

SAMPLE_UART_TX -- requirements
Module: sample_uart_tx

---
 rtl/fir_stream_pkg.sv | 19 +
 rtl/uart_byte_tx.sv | 84 ++++++++
 rtl/sample_uart_tx.sv | 93 +++++++++
 tb/tb_sample_uart_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_stream_pkg.sv
// fir_stream_pkg -- shared types and constants for the ECG sample serial link.
// Revision: 1.0
`default_nettype none

package fir_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam int         FRAME_BYTES       = 3;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

`default_nettype wire

// File: rtl/uart_byte_tx.sv
// uart_byte_tx -- one 8N1 byte on the serial line; chains straight into the next byte.
// Revision: 1.0
`default_nettype none

module uart_byte_tx
  import fir_stream_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byte_done
);

  localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

  tx_state_t   state;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        bit_end;

  assign bit_end   = (clk_cnt == LAST_CLK);
  // Last cycle of the stop bit: the caller may issue the next start here.
  assign byte_done = (state == ST_STOP) && bit_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      clk_cnt <= (state == ST_IDLE || bit_end) ? 16'd0 : clk_cnt + 16'd1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_START;
            shift <= data;
            tx    <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            bit_idx <= 3'd0;
            tx      <= shift[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
              shift   <= {1'b0, shift[7:1]};
            end
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (start) begin
              state <= ST_START;
              shift <= data;
              tx    <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sample_uart_tx.sv
// sample_uart_tx -- frames Q15 samples as SYNC/MSB/LSB over UART with a one-deep buffer.
// Revision: 1.0
`default_nettype none

module sample_uart_tx
  import fir_stream_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic signed [15:0] sample_in,
  input  logic               sample_valid,
  output logic               sample_ready,
  output logic               tx,
  output logic               busy,
  output logic [7:0]         drop_count
);

  localparam logic [1:0] LAST_BYTE = 2'(FRAME_BYTES - 1);

  logic [15:0] hold_data;
  logic [15:0] frame_data;
  logic        hold_full;
  logic [1:0]  byte_idx;
  logic        byte_done;
  logic        frame_end;
  logic        start_frame;
  logic        next_byte;
  logic        byte_start;
  logic        accept;
  logic        drop;
  logic [7:0]  byte_data;

  assign frame_end   = byte_done && (byte_idx == LAST_BYTE);
  assign start_frame = hold_full && (!busy || frame_end);
  assign next_byte   = byte_done && (byte_idx != LAST_BYTE);
  assign byte_start  = start_frame || next_byte;
  // The slot freed by start_frame is reusable in the same cycle, so such a sample is not a drop.
  assign accept      = sample_valid && (sample_ready || start_frame);
  assign drop        = sample_valid && !accept;

  always_comb begin
    byte_data = SYNC_BYTE;
    if (!start_frame) begin
      byte_data = (byte_idx == 2'd0) ? frame_data[15:8] : frame_data[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_data    <= '0;
      frame_data   <= '0;
      hold_full    <= 1'b0;
      sample_ready <= 1'b1;
      byte_idx     <= '0;
      busy         <= 1'b0;
      drop_count   <= '0;
    end else begin
      if (accept) hold_data <= sample_in;
      hold_full    <= accept || (hold_full && !start_frame);
      sample_ready <= !(accept || (hold_full && !start_frame));

      if (start_frame) begin
        frame_data <= hold_data;
        byte_idx   <= 2'd0;
        busy       <= 1'b1;
      end else if (next_byte) begin
        byte_idx <= byte_idx + 2'd1;
      end else if (frame_end) begin
        byte_idx <= 2'd0;
        busy     <= 1'b0;
      end

      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (byte_start),
    .data     (byte_data),
    .tx       (tx),
    .byte_done(byte_done)
  );

endmodule

`default_nettype wire

// File: tb/tb_sample_uart_tx.sv
// tb_sample_uart_tx -- directed vectors and frame-timing sequences for sample_uart_tx.
// Revision: 1.0
`default_nettype none

module tb_sample_uart_tx;

  typedef struct {
    logic [15:0] s;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } vec_t;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic signed [15:0] sample_in = '0;
  logic               sample_valid = 1'b0;
  logic               sample_ready;
  logic               tx;
  logic               busy;
  logic [7:0]         drop_count;

  int checks = 0;
  int errors = 0;

  sample_uart_tx #(
    .CLKS_PER_BIT(4),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .tx          (tx),
    .busy        (busy),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer at the edge after the current one; checks {tx,busy,ready} after edges 0 and 1.
  task automatic launch(input logic [15:0] s, input string name);
    sample_in    = s;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    chk($sformatf("%s accept", name), {29'd0, tx, busy, sample_ready}, 32'b100);
    step();
    chk($sformatf("%s start", name), {29'd0, tx, busy, sample_ready}, 32'b011);
  endtask

  // Entered on the first cycle of a start bit; consumes exactly 120 cycles.
  task automatic run_frame(input logic [7:0] hi, input logic [7:0] lo, input string name);
    logic [7:0] exp_b [3];
    int         busy_lo;
    exp_b[0] = 8'hA5;
    exp_b[1] = hi;
    exp_b[2] = lo;
    busy_lo  = 0;
    for (int b = 0; b < 3; b++) begin
      logic [9:0] word;
      logic       bad;
      word = '0;
      bad  = 1'b0;
      for (int j = 0; j < 10; j++) begin
        for (int c = 0; c < 4; c++) begin
          if (c == 0) word[j] = tx;
          else if (tx !== word[j]) bad = 1'b1;
          if (busy !== 1'b1) busy_lo++;
          step();
        end
      end
      chk($sformatf("%s byte%0d", name, b), {21'd0, bad, word}, {21'd0, 1'b0, 1'b1, exp_b[b], 1'b0});
    end
    chk($sformatf("%s busy_low_cycles", name), busy_lo, 0);
  endtask

  task automatic check_idle(input string name);
    chk($sformatf("%s idle", name), {29'd0, tx, busy, sample_ready}, 32'b101);
  endtask

  task automatic offer_after(input int n, input logic [15:0] v);
    repeat (n) @(posedge clk);
    #1;
    sample_in    = v;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  initial begin
    vec_t vecs [5];
    logic       quiet;
    int         n;
    vecs[0] = '{16'h1234, 8'h12, 8'h34};
    vecs[1] = '{16'h8001, 8'h80, 8'h01};
    vecs[2] = '{16'h7FFF, 8'h7F, 8'hFF};
    vecs[3] = '{16'h8000, 8'h80, 8'h00};
    vecs[4] = '{16'h00C3, 8'h00, 8'hC3};

    #22;
    chk("reset state", {20'd0, tx, busy, sample_ready, 1'b0, drop_count}, {20'd0, 3'b101, 1'b0, 8'h00});
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // First vector is offered immediately after release.
    for (int i = 0; i < 5; i++) begin
      launch(vecs[i].s, $sformatf("vec%0d", i));
      run_frame(vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));
      check_idle($sformatf("vec%0d", i));
    end
    chk("vec drop_count", {24'd0, drop_count}, 32'd0);

    // Back-to-back: second offered 10 cycles after the first.
    launch(16'h0001, "b2b_a");
    fork
      begin
        run_frame(8'h00, 8'h01, "b2b_a");
        run_frame(8'hFF, 8'hFF, "b2b_b");
      end
      offer_after(8, 16'hFFFF);
    join
    check_idle("b2b");
    chk("b2b drop_count", {24'd0, drop_count}, 32'd0);

    // Offer on the exact cycle the holding register is emptied into the frame.
    sample_in    = 16'h4321;
    sample_valid = 1'b1;
    step();
    sample_in = 16'hABCD;
    chk("simul first accepted", {31'd0, sample_ready}, 32'd0);
    step();
    sample_valid = 1'b0;
    chk("simul second accepted", {30'd0, tx, sample_ready}, 32'b00);
    run_frame(8'h43, 8'h21, "simul_a");
    run_frame(8'hAB, 8'hCD, "simul_b");
    check_idle("simul");
    chk("simul drop_count", {24'd0, drop_count}, 32'd0);

    // Overflow: three offers 10 cycles apart within one frame.
    launch(16'h1111, "ovf_a");
    fork
      begin
        run_frame(8'h11, 8'h11, "ovf_a");
        run_frame(8'h22, 8'h22, "ovf_b");
      end
      begin
        offer_after(8, 16'h2222);
        offer_after(9, 16'h3333);
      end
    join
    check_idle("ovf");
    chk("ovf drop_count", {24'd0, drop_count}, 32'd1);

    // Saturation: 300 cycles of continuous offers while frames run.
    launch(16'h5A5A, "sat");
    sample_in    = 16'h0F0F;
    sample_valid = 1'b1;
    repeat (300) step();
    sample_valid = 1'b0;
    chk("sat drop_count", {24'd0, drop_count}, 32'd255);
    n = 0;
    while (busy && n < 2000) begin
      step();
      n++;
    end
    check_idle("sat drained");
    chk("sat drop_count hold", {24'd0, drop_count}, 32'd255);

    // Reset at cycle 50 of a frame.
    launch(16'h5555, "rst");
    repeat (49) step();
    reset_n = 1'b0;
    #1;
    chk("rst async", {20'd0, tx, busy, sample_ready, 1'b0, drop_count}, {20'd0, 3'b101, 1'b0, 8'h00});
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    quiet   = 1'b1;
    repeat (20) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
    end
    chk("rst no resume", {31'd0, quiet}, 32'd1);
    launch(16'h00FF, "post_rst");
    run_frame(8'h00, 8'hFF, "post_rst");
    check_idle("post_rst");
    chk("post_rst drop_count", {24'd0, drop_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
